// File: rtl/stuck_bus_detector_if.sv
// Monitored-word bus for stuck_bus_detector: sample/control in, classification and sticky flags out.
interface stuck_bus_detector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             valid_in;
  logic [WIDTH-1:0] x;
  logic             clear;
  logic             valid_out;
  logic             zero;
  logic             one;
  logic [CNT_W-1:0] run_cnt;
  logic             stuck_zero;
  logic             stuck_one;

  modport master (
    output valid_in, x, clear,
    input  valid_out, zero, one, run_cnt, stuck_zero, stuck_one
  );

  modport slave (
    input  valid_in, x, clear,
    output valid_out, zero, one, run_cnt, stuck_zero, stuck_one
  );
endinterface

// File: rtl/stuck_bus_detector.sv
// Classifies each valid word as all-zero / all-one / mixed, tracks the current uniform run
// and raises sticky flags once a run of RUN_LEN identical-class words has been seen.
module stuck_bus_detector #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  stuck_bus_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    S_MIX = 2'd0,
    S_Z   = 2'd1,
    S_O   = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             valid_out_q, valid_out_d;
  logic             zero_q, zero_d;
  logic             one_q, one_d;
  logic             stuck_zero_q, stuck_zero_d;
  logic             stuck_one_q, stuck_one_d;

  logic             is_zero;
  logic             is_one;
  logic [CNT_W-1:0] run_inc;

  // For WIDTH=1 the two tests are complementary, so "mixed" can never occur.
  assign is_zero = (bus.x == '0);
  assign is_one  = (bus.x == ALL_ONES);
  assign run_inc = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    valid_out_d  = bus.valid_in;
    zero_d       = zero_q;
    one_d        = one_q;
    stuck_zero_d = stuck_zero_q;
    stuck_one_d  = stuck_one_q;

    if (bus.valid_in) begin
      zero_d = is_zero;
      one_d  = is_one;
    end

    // Clear still lets the word be classified, but it never starts a run or sets a flag.
    if (bus.clear) begin
      state_d      = S_MIX;
      run_cnt_d    = '0;
      stuck_zero_d = 1'b0;
      stuck_one_d  = 1'b0;
    end else if (bus.valid_in) begin
      if (is_zero) begin
        state_d   = S_Z;
        run_cnt_d = (state_q == S_Z) ? run_inc : CNT_W'(1);
        if (run_cnt_d >= RUN_LEN_C) stuck_zero_d = 1'b1;
      end else if (is_one) begin
        state_d   = S_O;
        run_cnt_d = (state_q == S_O) ? run_inc : CNT_W'(1);
        if (run_cnt_d >= RUN_LEN_C) stuck_one_d = 1'b1;
      end else begin
        state_d   = S_MIX;
        run_cnt_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_MIX;
      run_cnt_q    <= '0;
      valid_out_q  <= 1'b0;
      zero_q       <= 1'b0;
      one_q        <= 1'b0;
      stuck_zero_q <= 1'b0;
      stuck_one_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      valid_out_q  <= valid_out_d;
      zero_q       <= zero_d;
      one_q        <= one_d;
      stuck_zero_q <= stuck_zero_d;
      stuck_one_q  <= stuck_one_d;
    end
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.zero       = zero_q;
  assign bus.one        = one_q;
  assign bus.run_cnt    = run_cnt_q;
  assign bus.stuck_zero = stuck_zero_q;
  assign bus.stuck_one  = stuck_one_q;

endmodule

// File: tb/tb_stuck_bus_detector.sv
// Self-checking bench for stuck_bus_detector: directed scenarios plus randomized traffic
// compared against a run-length reference model.
module tb_stuck_bus_detector;

  localparam int RUN_LEN = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stuck_bus_detector_if #(.WIDTH(8), .CNT_W(4)) bus ();
  stuck_bus_detector_if #(.WIDTH(1), .CNT_W(4)) bus1 ();

  stuck_bus_detector #(.WIDTH(8), .RUN_LEN(RUN_LEN), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  stuck_bus_detector #(.WIDTH(1), .RUN_LEN(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unbounded run length per class, saturation applied only when comparing.
  bit m_vo, m_zero, m_one, m_sz, m_so;
  int m_run;
  int m_kind; // 0 = none, 1 = zeros, 2 = ones

  logic [8:0] got;
  assign got = {bus.valid_out, bus.zero, bus.one, bus.run_cnt, bus.stuck_zero, bus.stuck_one};

  function automatic logic [8:0] exp_vec();
    int c;
    c = (m_run > CNT_MAX) ? CNT_MAX : m_run;
    return {m_vo, m_zero, m_one, 4'(c), m_sz, m_so};
  endfunction

  function automatic void model_step(bit r, bit v, logic [7:0] xv, bit c);
    int cls;
    if (r) begin
      m_vo = 0; m_zero = 0; m_one = 0; m_sz = 0; m_so = 0; m_run = 0; m_kind = 0;
      return;
    end
    m_vo = v;
    if (v) begin
      m_zero = (xv == 8'h00);
      m_one  = (xv == 8'hFF);
    end
    if (c) begin
      m_run = 0; m_kind = 0; m_sz = 0; m_so = 0;
    end else if (v) begin
      cls = (xv == 8'h00) ? 1 : (xv == 8'hFF) ? 2 : 0;
      if (cls == 0) begin
        m_run = 0; m_kind = 0;
      end else if (cls == m_kind) begin
        m_run++;
      end else begin
        m_run = 1; m_kind = cls;
      end
      if (m_kind == 1 && m_run >= RUN_LEN) m_sz = 1;
      if (m_kind == 2 && m_run >= RUN_LEN) m_so = 1;
    end
  endfunction

  // Drive one cycle on the 8-bit bus, advance the model, and settle just after the edge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] xv, input bit c);
    rst          = r;
    bus.valid_in = v;
    bus.x        = xv;
    bus.clear    = c;
    @(posedge clk);
    model_step(r, v, xv, c);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 8'h00, 0);
    cycle(1, 1, 8'hFF, 1);
    n_checks++;
    if (got !== 9'b0) begin
      n_fail++;
      $display("FAIL reset: got %b expected %b", got, 9'b0);
    end
    cycle(0, 0, 8'h00, 0);
  endtask

  task automatic test_zero_run();
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'h00, 0);
      n_checks++;
      if (got !== exp_vec() || bus.run_cnt !== 4'(i + 1) || bus.stuck_zero !== (i == 3)) begin
        n_fail++;
        $display("FAIL zero_run[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_mixed_break();
    logic [7:0] xs [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'hFF};
    logic [3:0] cs [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, xs[i], 0);
      n_checks++;
      if (got !== exp_vec() || bus.run_cnt !== cs[i] || bus.stuck_one !== 1'b0 ||
          bus.one !== (xs[i] == 8'hFF)) begin
        n_fail++;
        $display("FAIL mixed_break[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_gaps();
    bit         vs [6] = '{1, 1, 1, 0, 0, 1};
    logic [3:0] cs [6] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, vs[i], 8'h00, 0);
      n_checks++;
      if (got !== exp_vec() || bus.run_cnt !== cs[i] || bus.valid_out !== vs[i] ||
          bus.stuck_zero !== (i == 5)) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_saturate_clear();
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 8'hFF, 0);
      n_checks++;
      if (got !== exp_vec() || bus.run_cnt !== 4'((i + 1 > 15) ? 15 : i + 1) ||
          bus.stuck_one !== (i >= 3)) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
    cycle(0, 1, 8'hFF, 1);
    n_checks++;
    if (got !== exp_vec() || got !== 9'b1_0_1_0000_0_0) begin
      n_fail++;
      $display("FAIL clear_with_valid: got %b expected %b", got, 9'b1_0_1_0000_0_0);
    end
    cycle(0, 1, 8'hFF, 0);
    n_checks++;
    if (got !== exp_vec() || bus.run_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL after_clear: got %b expected %b", got, exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, 0);
    cycle(1, 1, 8'h00, 0);
    n_checks++;
    if (got !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %b expected %b", got, 9'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'h00, 0);
      n_checks++;
      if (got !== exp_vec() || bus.run_cnt !== 4'(i + 1) || bus.stuck_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_run[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit         r, v, c;
    logic [7:0] xv;
    int         sel;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 29) == 0);
      sel = $urandom_range(0, 9);
      xv  = (sel < 4) ? 8'h00 : (sel < 8) ? 8'hFF : 8'($urandom);
      cycle(r, v, xv, c);
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_width1();
    logic [6:0] g1;
    cycle(1, 0, 8'h00, 0);
    bus1.valid_in = 1'b1;
    bus1.x        = 1'b0;
    cycle(0, 0, 8'h00, 0);
    g1 = {bus1.zero, bus1.one, bus1.run_cnt, bus1.stuck_zero};
    n_checks++;
    if (g1 !== 7'b1_0_0001_1 || bus1.stuck_one !== 1'b0) begin
      n_fail++;
      $display("FAIL width1_zero: got %b/%b expected 1000011/0", g1, bus1.stuck_one);
    end
    bus1.x = 1'b1;
    cycle(0, 0, 8'h00, 0);
    n_checks++;
    if (bus1.one !== 1'b1 || bus1.stuck_zero !== 1'b1 || bus1.stuck_one !== 1'b1 ||
        bus1.run_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL width1_one: got sz=%b so=%b cnt=%0d expected 1 1 1",
               bus1.stuck_zero, bus1.stuck_one, bus1.run_cnt);
    end
    bus1.valid_in = 1'b1;
    bus1.x        = 1'b0;
    cycle(0, 0, 8'h00, 0);
    bus1.valid_in = 1'b0;
    cycle(0, 0, 8'h00, 0);
    n_checks++;
    if (bus1.stuck_zero !== 1'b1 || bus1.stuck_one !== 1'b1 || bus1.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL width1_sticky: got sz=%b so=%b vo=%b expected 1 1 0",
               bus1.stuck_zero, bus1.stuck_one, bus1.valid_out);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.x         = '0;
    bus.clear     = 1'b0;
    bus1.valid_in = 1'b0;
    bus1.x        = '0;
    bus1.clear    = 1'b0;
    model_step(1, 0, 8'h00, 0);

    test_reset();
    test_zero_run();
    test_mixed_break();
    test_gaps();
    test_saturate_clear();
    test_reset_mid_run();
    test_random();
    test_width1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
